// File: rtl/div_controller.sv
// Sequencing FSM for the repeated-subtraction divider datapath, with an iteration watchdog.
// Optional feature macro: DIV_ZERO_CHECK_EN (short-circuits a zero divisor straight to DONE with err).
module div_controller #(
  parameter int                CNT_W    = 32,
  parameter logic [CNT_W-1:0]  MAX_ITER = CNT_W'(32'hFFFF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             b_less,
  input  logic             b_zero,
  input  logic             ack,
  output logic             ld,
  output logic             mux,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  logic   limit;

`ifndef DIV_ZERO_CHECK_EN
  logic unused_b_zero;
  assign unused_b_zero = b_zero;
`endif

  assign limit = (iter_count == MAX_ITER);

  // The datapath must not load once the watchdog has tripped, so ld is gated by limit.
  always_comb begin
    ld  = 1'b0;
    mux = 1'b0;
    case (state)
      LOAD: begin
        ld  = 1'b1;
        mux = 1'b0;
      end
      ITER: begin
        ld  = ~b_less & ~limit;
        mux = 1'b1;
      end
      default: begin
        ld  = 1'b0;
        mux = 1'b0;
      end
    endcase
  end

  // busy and done are kept as flops alongside the state so they leave the block glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      iter_count <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            iter_count <= '0;
`ifdef DIV_ZERO_CHECK_EN
            if (b_zero) begin
              state <= DONE;
              err   <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= LOAD;
              err   <= 1'b0;
              busy  <= 1'b1;
            end
`else
            state <= LOAD;
            err   <= 1'b0;
            busy  <= 1'b1;
`endif
          end
        end
        LOAD: begin
          state <= ITER;
        end
        ITER: begin
          // A finished divide wins over the watchdog in the same cycle.
          if (b_less) begin
            state <= DONE;
            err   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (limit) begin
            state <= DONE;
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            iter_count <= iter_count + 1'b1;
          end
        end
        DONE: begin
          if (ack) begin
            done <= 1'b0;
            if (start) begin
              state      <= LOAD;
              iter_count <= '0;
              err        <= 1'b0;
              busy       <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_controller.sv
// Scoreboard bench for div_controller: a behavioural datapath drives b_less, and
// expected quotient/remainder/latency come from plain division arithmetic.
module tb_div_controller;

  localparam int          CNT_W    = 32;
  localparam int unsigned MAX_ITER = 12;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             b_less;
  logic             b_zero;
  logic             ack;
  logic             ld;
  logic             mux;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] iter_count;

  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] rem_reg;
  logic [31:0] quot_reg;

  typedef struct {
    int unsigned start_edge;
    int unsigned lat;
    int unsigned iter;
    int unsigned ld_cycles;
    logic        err;
    logic [31:0] div;
    logic [31:0] mod;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc;
  int          checks;
  int          failures;

  div_controller #(
    .CNT_W    (CNT_W),
    .MAX_ITER (32'(MAX_ITER))
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .b_less     (b_less),
    .b_zero     (b_zero),
    .ack        (ack),
    .ld         (ld),
    .mux        (mux),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .iter_count (iter_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Behavioural datapath: load A / clear count, or subtract B / increment count.
  always @(posedge clk) begin
    if (ld) begin
      if (!mux) begin
        rem_reg  <= a_in;
        quot_reg <= '0;
      end else begin
        rem_reg  <= rem_reg - b_in;
        quot_reg <= quot_reg + 1;
      end
    end
  end
  assign b_less = (rem_reg < b_in);
  assign b_zero = (b_in == 32'd0);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: quotient by plain division, capped by the watchdog.
  task automatic pushExpected(input logic [31:0] a, input logic [31:0] b, input int unsigned s_edge, input bit from_idle);
    exp_t e;
    longint unsigned q;
    e.start_edge = s_edge;
    e.div = '0;
    e.mod = '0;
    if (b == 0) q = 64'hFFFF_FFFF_FFFF;
    else        q = longint'(a / b);
`ifdef DIV_ZERO_CHECK_EN
    if (b == 0 && from_idle) begin
      e.err = 1'b1; e.iter = 0; e.lat = 1; e.ld_cycles = 0;
      exp_q.push_back(e);
      return;
    end
`else
    if (from_idle) begin end
`endif
    if (q <= MAX_ITER) begin
      e.err = 1'b0; e.iter = int'(q); e.div = a / b; e.mod = a % b;
    end else begin
      e.err = 1'b1; e.iter = MAX_ITER;
    end
    e.lat       = e.iter + 2;
    e.ld_cycles = e.iter + 1;
    exp_q.push_back(e);
  endtask

  task automatic waitDone();
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    checkOutput("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input int hold, input bit mid_pulse);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    pushExpected(a, b, cyc + 1, 1'b1);
    @(negedge clk);
    start = 1'b0;
    if (mid_pulse) begin
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ack   = 1'b1;
      @(negedge clk);
      ack   = 1'b0;
    end
    waitDone();
    repeat (hold) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  // Monitor: pops one expectation per rising done and checks result stability while done holds.
  initial begin : monitor
    logic        done_q;
    int unsigned ld_cnt;
    bit          have_cur;
    exp_t        cur;
    done_q   = 1'b0;
    ld_cnt   = 0;
    have_cur = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        done_q   = 1'b0;
        ld_cnt   = 0;
        have_cur = 1'b0;
      end else begin
        if (ld) ld_cnt = ld_cnt + 1;
        if (done && !done_q) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_done", {31'd0, done}, 32'd0);
          end else begin
            cur      = exp_q.pop_front();
            have_cur = 1'b1;
            checkOutput("latency", cyc - cur.start_edge, cur.lat);
            checkOutput("err", {31'd0, err}, {31'd0, cur.err});
            checkOutput("iter_count", iter_count, cur.iter);
            checkOutput("ld_cycles", ld_cnt, cur.ld_cycles);
            checkOutput("busy_in_done", {31'd0, busy}, 32'd0);
            if (!cur.err) begin
              checkOutput("div", quot_reg, cur.div);
              checkOutput("mod", rem_reg, cur.mod);
            end
          end
          ld_cnt = 0;
        end else if (done && have_cur) begin
          checkOutput("ld_in_done", {31'd0, ld}, 32'd0);
          checkOutput("err_hold", {31'd0, err}, {31'd0, cur.err});
          if (!cur.err) begin
            checkOutput("div_stable", quot_reg, cur.div);
            checkOutput("mod_stable", rem_reg, cur.mod);
          end
        end
        done_q = done;
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    ack      = 1'b0;
    a_in     = '0;
    b_in     = 32'd1;
    #1;
    checkOutput("rst_ld", {31'd0, ld}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_iter", iter_count, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed operations");
    applyStimulus(32'd17, 32'd5, 0, 1'b0);
    applyStimulus(32'd3,  32'd7, 1, 1'b0);
    applyStimulus(32'd5,  32'd0, 0, 1'b0);
    applyStimulus(32'd24, 32'd2, 0, 1'b0);
    applyStimulus(32'd26, 32'd2, 0, 1'b0);
    applyStimulus(32'd60, 32'd7, 2, 1'b1);

    $display("[TB] back-to-back with held ack");
    @(negedge clk);
    a_in  = 32'd100;
    b_in  = 32'd10;
    start = 1'b1;
    pushExpected(32'd100, 32'd10, cyc + 1, 1'b1);
    @(negedge clk);
    start = 1'b0;
    waitDone();
    repeat (5) @(negedge clk);
    a_in  = 32'd9;
    b_in  = 32'd2;
    start = 1'b1;
    ack   = 1'b1;
    pushExpected(32'd9, 32'd2, cyc + 1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    ack   = 1'b0;
    waitDone();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;

    $display("[TB] reset mid-iteration");
    @(negedge clk);
    a_in  = 32'd50;
    b_in  = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_ld", {31'd0, ld}, 32'd0);
    checkOutput("arst_mux", {31'd0, mux}, 32'd0);
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    checkOutput("arst_done", {31'd0, done}, 32'd0);
    checkOutput("arst_iter", iter_count, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(32'd50, 32'd5, 0, 1'b0);

    $display("[TB] randomized operations");
    for (int n = 0; n < 25; n++) begin
      applyStimulus(32'($urandom_range(0, 150)), 32'($urandom_range(0, 15)),
                    int'($urandom_range(0, 3)), 1'b0);
    end

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
